// File: rtl/alu_pipe.sv
// Handshaked, parametrised ALU with a registered result and status flags.
// Single-cycle logic/arith/shift/compare ops plus an iterative shift-add multiply.
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opsel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned CNTW = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_MVHI = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_SLT  = 4'd12;
  localparam logic [3:0] OP_SLTU = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e            state_q,     state_d;
  logic [CNTW-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0]  acc_q,       acc_d;
  logic [WIDTH-1:0]  mcand_q,     mcand_d;
  logic [WIDTH-1:0]  mplier_q,    mplier_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  result_q,    result_d;
  logic              zero_q,      zero_d;
  logic              negative_q,  negative_d;
  logic              carry_q,     carry_d;
  logic              overflow_q,  overflow_d;
  logic              illegal_q,   illegal_d;

  logic              accept;
  logic [SHW-1:0]    shamt;
  logic [WIDTH:0]    sum_ext;
  logic [WIDTH:0]    diff_ext;
  logic [WIDTH-1:0]  mul_sum;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_carry;
  logic              alu_ovf;
  logic              alu_ill;

  // Ready only when idle and the output slot is free or draining; forced low in reset.
  assign in_ready = reset_n & (state_q == S_IDLE) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  assign shamt    = b[SHW-1:0];
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle datapath; MUL is produced by the iterative path instead.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (opsel)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NAND: alu_res = ~(a & b);
      OP_NOR:  alu_res = ~(a | b);
      OP_XNOR: alu_res = ~(a ^ b);
      OP_MVHI: alu_res = {b[HALF-1:0], a[HALF-1:0]};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_res = WIDTH'(a < b);
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state, multiply iteration and output-register load/hold.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    out_valid_d = out_valid_q & ~out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (opsel == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            negative_d  = alu_res[WIDTH-1];
            carry_d     = alu_carry;
            overflow_d  = alu_ovf;
            illegal_d   = alu_ill;
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_sum;
          zero_d      = (mul_sum == '0);
          negative_d  = mul_sum[WIDTH-1];
          carry_d     = 1'b0;
          overflow_d  = 1'b0;
          illegal_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push expectations, a monitor
// pops and compares on every output handshake and checks stall stability.
module tb_alu_pipe;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opsel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero, negative, carry, overflow, illegal;
  logic [36:0]  obs;

  logic [36:0]  exp_q[$];
  string        name_q[$];
  int           n_tests;
  int           n_fail;
  int           rdy_mode;
  int           rdy_idx;
  logic [15:0]  rdy_pat;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opsel     (opsel),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  assign obs = {result, zero, negative, carry, overflow, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected {result, zero, negative, carry, overflow, illegal}.
  function automatic logic [36:0] mk(input logic [31:0] r, input logic c, input logic v,
                                     input logic ill);
    return {r, (r == 32'd0), r[31], c, v, ill};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [36:0] e, input string nm, input bit lat);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    opsel    = op;
    a        = xa;
    b        = xb;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept: in_ready 0 after %0d cycles, expected 1", nm, waited);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      opsel    = 4'd0;
      a        = '0;
      b        = '0;
      if (lat) begin
        @(negedge clk);
        chk({nm, "_latency"}, 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic mul_run(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] r,
                         input string nm);
    int bad;
    bad = 0;
    issue(4'd14, xa, xb, mk(r, 1'b0, 1'b0, 1'b0), nm, 1'b0);
    repeat (W) begin
      @(negedge clk);
      if (out_valid || in_ready) bad++;
    end
    chk({nm, "_busy_cycles"}, 64'(bad), 64'd0);
    @(negedge clk);
    chk({nm, "_latency"}, 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Output-side consumer: always ready, or a fixed stall pattern.
  initial begin
    rdy_pat = 16'b0110_0010_1100_0101;
    rdy_idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != 0) begin
        out_ready = rdy_pat[rdy_idx % 16];
        rdy_idx++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops on each handshake, checks held outputs while stalled.
  initial begin
    logic [36:0] held;
    logic        held_v;
    logic [36:0] e;
    string       nm;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_stable", 64'(obs), 64'(held));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", obs);
          end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, 64'(obs), 64'(e));
          end
          held_v = 1'b0;
        end else if (out_valid) begin
          held_v = 1'b1;
          held   = obs;
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int bad;
    n_tests   = 0;
    n_fail    = 0;
    rdy_mode  = 0;
    in_valid  = 1'b0;
    opsel     = 4'd0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    reset_n   = 1'b0;

    #1;
    chk("reset_outputs", 64'(obs), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    #20;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    issue(4'd0,  32'd20, 32'd17, mk(32'd37,         1'b0, 1'b0, 1'b0), "add",  1'b1);
    issue(4'd1,  32'd20, 32'd17, mk(32'd3,          1'b0, 1'b0, 1'b0), "sub",  1'b1);
    issue(4'd2,  32'd20, 32'd17, mk(32'd16,         1'b0, 1'b0, 1'b0), "and",  1'b1);
    issue(4'd3,  32'd20, 32'd17, mk(32'd21,         1'b0, 1'b0, 1'b0), "or",   1'b1);
    issue(4'd4,  32'd20, 32'd17, mk(32'd5,          1'b0, 1'b0, 1'b0), "xor",  1'b1);
    issue(4'd5,  32'd20, 32'd17, mk(32'hFFFF_FFEF,  1'b0, 1'b0, 1'b0), "nand", 1'b1);
    issue(4'd6,  32'd20, 32'd17, mk(32'hFFFF_FFEA,  1'b0, 1'b0, 1'b0), "nor",  1'b1);
    issue(4'd7,  32'd20, 32'd17, mk(32'hFFFF_FFFA,  1'b0, 1'b0, 1'b0), "xnor", 1'b1);
    issue(4'd8,  32'd20, 32'd17, mk(32'h0011_0014,  1'b0, 1'b0, 1'b0), "mvhi", 1'b1);

    issue(4'd0,  32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0), "add_ovf",   1'b0);
    issue(4'd0,  32'hFFFF_FFFF, 32'd1, mk(32'd0,         1'b1, 1'b0, 1'b0), "add_carry", 1'b0);
    issue(4'd1,  32'd17, 32'd20,       mk(32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0), "sub_borrow", 1'b0);
    issue(4'd1,  32'd5,  32'd5,        mk(32'd0,         1'b0, 1'b0, 1'b0), "sub_zero",  1'b0);
    issue(4'd15, 32'd20, 32'd17,       mk(32'd0,         1'b0, 1'b0, 1'b1), "illegal",   1'b0);

    issue(4'd11, 32'h8000_0000, 32'h24, mk(32'hF800_0000, 1'b0, 1'b0, 1'b0), "sra", 1'b0);
    issue(4'd10, 32'h8000_0000, 32'h24, mk(32'h0800_0000, 1'b0, 1'b0, 1'b0), "srl", 1'b0);
    issue(4'd9,  32'd3,         32'd4,  mk(32'h0000_0030, 1'b0, 1'b0, 1'b0), "sll", 1'b0);
    issue(4'd9,  32'h1234_5678, 32'h20, mk(32'h1234_5678, 1'b0, 1'b0, 1'b0), "sll_by0", 1'b0);
    issue(4'd12, 32'hFFFF_FFFF, 32'd1,  mk(32'd1,         1'b0, 1'b0, 1'b0), "slt",  1'b0);
    issue(4'd13, 32'hFFFF_FFFF, 32'd1,  mk(32'd0,         1'b0, 1'b0, 1'b0), "sltu", 1'b0);

    mul_run(32'd20, 32'd17, 32'd340, "mul_20x17");
    mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, "mul_ones");

    // Consumer stalls on a fixed pattern; results must come out in order, once each.
    rdy_mode = 1;
    issue(4'd0, 32'd1, 32'd1, mk(32'd2, 1'b0, 1'b0, 1'b0), "bp_add1", 1'b0);
    issue(4'd0, 32'd2, 32'd2, mk(32'd4, 1'b0, 1'b0, 1'b0), "bp_add2", 1'b0);
    issue(4'd0, 32'd3, 32'd3, mk(32'd6, 1'b0, 1'b0, 1'b0), "bp_add3", 1'b0);
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    rdy_mode = 0;
    chk("bp_drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a multiply aborts it.
    issue(4'd14, 32'd20, 32'd17, mk(32'd340, 1'b0, 1'b0, 1'b0), "mul_aborted", 1'b0);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midmul_reset_outputs", 64'(obs), 64'd0);
    chk("midmul_reset_out_valid", 64'(out_valid), 64'd0);
    chk("midmul_reset_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    name_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("in_ready_after_midmul_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    issue(4'd0, 32'd1, 32'd1, mk(32'd2, 1'b0, 1'b0, 1'b0), "add_after_reset", 1'b1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("no_stale_mul_result", 64'(bad), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
